// File: rtl/alu_pkg.sv
// alu_pkg: shared op encodings and sequencer state type for the execute-stage ALU
package alu_pkg;
    localparam logic [3:0] ALU_AND   = 4'b0000;
    localparam logic [3:0] ALU_OR    = 4'b0001;
    localparam logic [3:0] ALU_ADD   = 4'b0010;
    localparam logic [3:0] ALU_SUB   = 4'b0110;
    localparam logic [3:0] ALU_SLT   = 4'b0111;
    localparam logic [3:0] ALU_MULTU = 4'b1000;
    localparam logic [3:0] ALU_MULT  = 4'b1001;
    localparam logic [3:0] ALU_DIVU  = 4'b1010;
    localparam logic [3:0] ALU_DIV   = 4'b1011;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
endpackage

// File: rtl/muldiv_seq.sv
// muldiv_seq: iterative shift-add multiplier / restoring divider with sign correction
module muldiv_seq #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             step,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       op,
    output logic             last,
    output logic [WIDTH-1:0] res_hi,
    output logic [WIDTH-1:0] res_lo
);
    logic [WIDTH-1:0]   m_q, m_d, abs_a, abs_b, quo, rem;
    logic [2*WIDTH-1:0] acc_q, acc_d, prod;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH:0]     msum, rtry, rdiff;
    logic               div_q, div_d, neg_q, neg_d, rneg_q, rneg_d, dz_q, dz_d;

    // Load magnitudes on launch, then one mul/div step per cycle; results are sign-fixed combinationally
    always_comb begin
        abs_a  = (op[0] && a[WIDTH-1]) ? -a : a;
        abs_b  = (op[0] && b[WIDTH-1]) ? -b : b;
        msum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, m_q} : '0);
        rtry   = acc_q[2*WIDTH-1:WIDTH-1];
        rdiff  = rtry - {1'b0, m_q};
        m_d    = m_q;
        acc_d  = acc_q;
        cnt_d  = cnt_q;
        div_d  = div_q;
        neg_d  = neg_q;
        rneg_d = rneg_q;
        dz_d   = dz_q;
        if (load) begin
            m_d    = op[1] ? abs_b : abs_a;
            acc_d  = {{WIDTH{1'b0}}, op[1] ? abs_a : abs_b};
            cnt_d  = '0;
            div_d  = op[1];
            neg_d  = op[0] & (a[WIDTH-1] ^ b[WIDTH-1]);
            rneg_d = op[0] & a[WIDTH-1];
            dz_d   = op[1] & (b == '0);
        end else if (step) begin
            cnt_d = cnt_q + 1'b1;
            acc_d = !div_q     ? {msum, acc_q[WIDTH-1:1]} :
                    rdiff[WIDTH] ? {rtry[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0} :
                                   {rdiff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
        end
        prod   = neg_q ? -acc_q : acc_q;
        quo    = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
        rem    = rneg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
        res_hi = div_q ? rem : prod[2*WIDTH-1:WIDTH];
        res_lo = div_q ? (dz_q ? '1 : quo) : prod[WIDTH-1:0];
        last   = cnt_q == CNT_W'(WIDTH - 1);
    end

    // Datapath registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            m_q    <= '0;
            acc_q  <= '0;
            cnt_q  <= '0;
            div_q  <= 1'b0;
            neg_q  <= 1'b0;
            rneg_q <= 1'b0;
            dz_q   <= 1'b0;
        end else begin
            m_q    <= m_d;
            acc_q  <= acc_d;
            cnt_q  <= cnt_d;
            div_q  <= div_d;
            neg_q  <= neg_d;
            rneg_q <= rneg_d;
            dz_q   <= dz_d;
        end
    end
endmodule

// File: rtl/alu_muldiv.sv
// alu_muldiv: execute-stage ALU with single-cycle ops and an iterative MULT/DIV unit writing HI/LO
module alu_muldiv
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [3:0]       F,
    input  logic             start,
    input  logic             flush,
    output logic [WIDTH-1:0] Y,
    output logic             zero,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    state_t           state_q, state_d;
    logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d, bx, s, res_hi, res_lo;
    logic             legal, load, step, last;

    muldiv_seq #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_seq (
        .clk(clk), .reset(reset), .load(load), .step(step), .a(A), .b(B), .op(F[1:0]),
        .last(last), .res_hi(res_hi), .res_lo(res_lo)
    );

    // Single-cycle result, independent of the sequencer
    always_comb begin
        bx   = F[2] ? ~B : B;
        s    = A + bx + {{(WIDTH-1){1'b0}}, F[2]};
        Y    = F[3]          ? '0 :
               F[1:0] == 2'b00 ? A & bx :
               F[1:0] == 2'b01 ? A | bx :
               F[1:0] == 2'b10 ? s : {{(WIDTH-1){1'b0}}, s[WIDTH-1]};
        zero = Y == '0;
    end

    // Sequencer next state; a flushed DONE cycle neither pulses done nor commits HI/LO
    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        step    = 1'b0;
        busy    = 1'b0;
        done    = 1'b0;
        legal   = (F & 4'b1100) == ALU_MULTU;
        case (state_q)
            S_IDLE: if (start && legal && !flush) begin
                state_d = S_RUN;
                load    = 1'b1;
            end
            S_RUN: begin
                busy    = 1'b1;
                step    = !flush;
                state_d = flush ? S_IDLE : last ? S_DONE : S_RUN;
            end
            S_DONE: begin
                done    = !flush;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        hi_d = done ? res_hi : hi_q;
        lo_d = done ? res_lo : lo_q;
        hi   = hi_d;
        lo   = lo_d;
    end

    // State and HI/LO registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end
endmodule

// File: tb/tb_alu_muldiv.sv
// tb_alu_muldiv: randomized scoreboard bench for alu_muldiv against an arithmetic reference model
module tb_alu_muldiv;
    import alu_pkg::*;

    logic        clk = 1'b0, reset = 1'b1, start = 1'b0, flush = 1'b0;
    logic [31:0] A = '0, B = '0;
    logic [3:0]  F = '0;
    logic [31:0] Y, hi, lo;
    logic        zero, busy, done;
    int          total = 0, passed = 0;
    logic [63:0] expq[$];
    logic [63:0] last_res = '0;

    alu_muldiv #(.WIDTH(32), .CNT_W(6)) dut (
        .clk(clk), .reset(reset), .A(A), .B(B), .F(F), .start(start), .flush(flush),
        .Y(Y), .zero(zero), .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    initial forever #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, required finish before 500000");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %h required %h", name, act, exp);
        else passed++;
    endtask

    function automatic logic [31:0] yref(input logic [31:0] a, input logic [31:0] b, input logic [3:0] f);
        logic [31:0] bx, s;
        bx = f[2] ? ~b : b;
        s  = f[2] ? a - b : a + b;
        if (f[3]) return '0;
        case (f[1:0])
            2'd0: return a & bx;
            2'd1: return a | bx;
            2'd2: return s;
            default: return {31'b0, s[31]};
        endcase
    endfunction

    function automatic logic [63:0] mref(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op);
        longint sa, sb;
        logic [63:0] p, q, r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            2'd0: p = {32'b0, a} * {32'b0, b};
            2'd1: p = sa * sb;
            2'd2: p = (b == 0) ? {a, 32'hFFFFFFFF} : {a % b, a / b};
            default: begin
                q = sa / ((b == 0) ? 1 : sb);
                r = sa % ((b == 0) ? 1 : sb);
                p = (b == 0) ? {a, 32'hFFFFFFFF} : {r[31:0], q[31:0]};
            end
        endcase
        return p;
    endfunction

    // Monitor: every done pulse is matched against the oldest expected HI/LO pair
    always @(negedge clk) begin
        if (!reset && done) begin
            if (expq.size() == 0) begin
                total++;
                $display("FAIL unexpected_done: got hi=%h lo=%h, required no done", hi, lo);
            end else chk("hilo", {hi, lo}, expq.pop_front());
        end
    end

    task automatic sc(input logic [31:0] a, input logic [31:0] b, input logic [3:0] f);
        @(negedge clk);
        A = a; B = b; F = f;
        #1;
        chk("Y", 64'(Y), 64'(yref(a, b, f)));
        chk("zero", 64'(zero), 64'(yref(a, b, f) == 0));
    endtask

    task automatic mc(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op);
        int bc = 0, dc = 0;
        @(negedge clk);
        A = a; B = b; F = {2'b10, op}; start = 1'b1;
        last_res = mref(a, b, op);
        expq.push_back(last_res);
        @(negedge clk);
        start = 1'b0; A = $urandom; B = $urandom;
        for (int c = 1; c <= 34; c++) begin
            if (busy) bc++;
            if (done && dc == 0) dc = c;
            @(negedge clk);
        end
        chk("busy_cycles", 64'(bc), 64'd32);
        chk("done_cycle", 64'(dc), 64'd33);
    endtask

    initial begin
        int dn;
        logic [31:0] ra, rb;
        @(negedge clk);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_hilo", {hi, lo}, 64'd0);
        reset = 1'b0;

        sc(7, 5, ALU_ADD);
        sc(7, 5, ALU_SUB);
        sc(7, 5, ALU_SLT);
        sc(32'hFFFFFFFF, 1, ALU_SLT);
        sc(32'hF0F0, 32'h0FF0, ALU_AND);
        sc(32'hF0F0, 32'h0FF0, ALU_OR);
        sc(32'h7FFFFFFF, 1, 4'b0011);
        sc(32'hF0F0, 32'h0FF0, 4'b0100);
        sc(32'h1234, 32'h5678, ALU_MULT);
        for (int i = 0; i < 40; i++) sc($urandom, ($urandom_range(0, 4) == 0) ? 32'($urandom_range(0, 3)) : $urandom, 4'($urandom));

        mc(32'hFFFFFFFF, 2, 2'd0);
        mc(32'hFFFFFFFD, 5, 2'd1);
        mc(32'hFFFFFFF9, 2, 2'd3);
        mc(100, 0, 2'd2);
        mc(32'h80000000, 32'hFFFFFFFF, 2'd3);
        mc(32'hFFFFFF9C, 0, 2'd3);
        mc(32'h80000000, 32'h80000000, 2'd1);
        for (int i = 0; i < 12; i++) begin
            ra = ($urandom_range(0, 2) == 0) ? 32'($urandom_range(0, 300)) - 150 : $urandom;
            rb = ($urandom_range(0, 5) == 0) ? 32'd0 : ($urandom_range(0, 2) == 0) ? 32'($urandom_range(0, 20)) - 10 : $urandom;
            mc(ra, rb, 2'($urandom_range(0, 3)));
        end

        @(negedge clk);
        A = 100; B = 7; F = ALU_DIVU; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        dn = 0;
        for (int c = 1; c <= 40; c++) begin
            start = (c == 10);
            if (c == 10) begin A = 3; B = 3; F = ALU_MULTU; end
            flush = (c == 20);
            if (c == 20) chk("busy_before_flush", 64'(busy), 64'd1);
            if (c == 21) chk("busy_after_flush", 64'(busy), 64'd0);
            if (done) dn++;
            @(negedge clk);
        end
        start = 1'b0; flush = 1'b0;
        chk("flush_no_done", 64'(dn), 64'd0);
        chk("flush_hilo_kept", {hi, lo}, last_res);

        A = 5; B = 5; F = ALU_MULT; start = 1'b1; flush = 1'b1;
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        chk("flush_start_idle", 64'(busy), 64'd0);
        chk("flush_start_hilo", {hi, lo}, last_res);

        A = 32'hFFFF; B = 32'hFFFF; F = ALU_MULTU; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (14) @(negedge clk);
        chk("busy_mid_run", 64'(busy), 64'd1);
        reset = 1'b1;
        #1;
        chk("async_rst_busy", 64'(busy), 64'd0);
        chk("async_rst_hilo", {hi, lo}, 64'd0);
        @(negedge clk);
        reset = 1'b0;
        last_res = '0;

        dn = 0;
        for (int c = 0; c < 6; c++) begin
            F = c[0] ? 4'b1110 : 4'b1101; A = $urandom; B = $urandom; start = (c < 2);
            @(negedge clk);
            if (busy || done) dn++;
        end
        start = 1'b0;
        chk("illegal_op_no_busy", 64'(dn), 64'd0);
        chk("illegal_op_hilo", {hi, lo}, 64'd0);

        mc(12345, 678, 2'd2);
        repeat (3) @(negedge clk);
        chk("queue_empty", 64'(expq.size()), 64'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
